// File: rtl/prf_wr_bank_arbiter_pkg.sv
// Shared types, sizes and PR field helpers for the PRF write-bank arbiter.
//   PR_t        : 7-bit physical register index; low bits select the bank, high bits the row.
//   upper_PR_t  : row within a bank.
//   prf_wr_src_t: index of a PRF writer (WR_BUF, LDU b0/b1, ALU rr, MDU, ALU ri, BRU, SYSU).
package prf_wr_bank_arbiter_pkg;

    localparam int unsigned XLEN                     = 32;
    localparam int unsigned PRF_WR_COUNT             = 8;
    localparam int unsigned PRF_BANK_COUNT           = 4;
    localparam int unsigned LOG_PRF_BANK_COUNT       = 2;
    localparam int unsigned PRF_WR_INPUT_BUFFER_SIZE = 2;
    localparam int unsigned PR_WIDTH                 = 7;

    typedef logic [PR_WIDTH-1:0]                      PR_t;
    typedef logic [PR_WIDTH-LOG_PRF_BANK_COUNT-1:0]   upper_PR_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0]            bank_t;
    typedef logic [$clog2(PRF_WR_COUNT)-1:0]          prf_wr_src_t;
    typedef logic [XLEN-1:0]                          data_t;

    typedef struct packed {
        PR_t   pr;
        data_t data;
    } wr_entry_t;

    function automatic bank_t PR_bank_bits(input PR_t pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

    function automatic upper_PR_t upper_PR_bits(input PR_t pr);
        return pr[PR_WIDTH-1:LOG_PRF_BANK_COUNT];
    endfunction

endpackage

// File: rtl/prf_wr_bank_arbiter_if.sv
// Writer-side request bus and bank-side write bus of the PRF write-bank arbiter.
//   req_valid/req_ready/req_PR/req_data : one lane per writer, write taken iff valid & ready.
//   bank_wr_valid/upper_PR/data/src     : one lane per PRF bank, registered.
// master: the writeback pipes plus PRF banks (testbench side); slave: the arbiter.
interface prf_wr_bank_arbiter_if;
    import prf_wr_bank_arbiter_pkg::*;

    logic        [PRF_WR_COUNT-1:0]   req_valid;
    logic        [PRF_WR_COUNT-1:0]   req_ready;
    PR_t         [PRF_WR_COUNT-1:0]   req_PR;
    data_t       [PRF_WR_COUNT-1:0]   req_data;

    logic        [PRF_BANK_COUNT-1:0] bank_wr_valid;
    upper_PR_t   [PRF_BANK_COUNT-1:0] bank_wr_upper_PR;
    data_t       [PRF_BANK_COUNT-1:0] bank_wr_data;
    prf_wr_src_t [PRF_BANK_COUNT-1:0] bank_wr_src;

    modport master (
        output req_valid, req_PR, req_data,
        input  req_ready, bank_wr_valid, bank_wr_upper_PR, bank_wr_data, bank_wr_src
    );

    modport slave (
        input  req_valid, req_PR, req_data,
        output req_ready, bank_wr_valid, bank_wr_upper_PR, bank_wr_data, bank_wr_src
    );

endinterface

// File: rtl/prf_wr_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : last winner; search starts at (ptr_i + 1) mod N
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester (0 when none)
//   valid_o : any request granted
module prf_wr_rr_arbiter #(
    parameter int unsigned N    = 8,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        // Visit ptr+1 .. ptr+N so the previous winner is considered last.
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/prf_wr_bank_arbiter.sv
// Shares the single-write-port PRF banks among the PRF writers.
// Each writer has a small input FIFO; every cycle each bank grants, round-robin, one FIFO head
// whose PR maps to that bank. Bank outputs are registered (min latency request->bank is 2 cycles).
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : slave side of prf_wr_bank_arbiter_if (writer requests in, bank writes out)
module prf_wr_bank_arbiter
    import prf_wr_bank_arbiter_pkg::*;
(
    input logic                  CLK,
    input logic                  nRST,
    prf_wr_bank_arbiter_if.slave bus
);

    localparam int unsigned WrCount    = PRF_WR_COUNT;
    localparam int unsigned BankCount  = PRF_BANK_COUNT;
    localparam int unsigned BufEntries = PRF_WR_INPUT_BUFFER_SIZE;
    // Pointers carry one wrap bit above the index so full and empty are distinguishable.
    // Depth must be a power of two.
    localparam int unsigned IdxW       = $clog2(BufEntries);
    localparam int unsigned PtrW       = IdxW + 1;

    // FIFO storage and pointers
    wr_entry_t       fifo_q   [WrCount][BufEntries];
    logic [PtrW-1:0] wr_ptr_q [WrCount];
    logic [PtrW-1:0] wr_ptr_d [WrCount];
    logic [PtrW-1:0] rd_ptr_q [WrCount];
    logic [PtrW-1:0] rd_ptr_d [WrCount];

    // Per-bank round-robin pointer (last winner)
    prf_wr_src_t rr_ptr_q [BankCount];
    prf_wr_src_t rr_ptr_d [BankCount];

    // Registered bank outputs
    logic        [BankCount-1:0] bank_valid_q, bank_valid_d;
    upper_PR_t   [BankCount-1:0] bank_upper_q, bank_upper_d;
    data_t       [BankCount-1:0] bank_data_q,  bank_data_d;
    prf_wr_src_t [BankCount-1:0] bank_src_q,   bank_src_d;

    logic      [WrCount-1:0] empty;
    logic      [WrCount-1:0] full;
    logic      [WrCount-1:0] enq;
    logic      [WrCount-1:0] deq;
    wr_entry_t [WrCount-1:0] head;

    logic        [BankCount-1:0][WrCount-1:0] elig;
    logic        [BankCount-1:0][WrCount-1:0] gnt;
    prf_wr_src_t [BankCount-1:0]              win_idx;
    logic        [BankCount-1:0]              win_vld;

    always_comb begin
        for (int unsigned w = 0; w < WrCount; w++) begin
            empty[w] = (wr_ptr_q[w] == rd_ptr_q[w]);
            full[w]  = (wr_ptr_q[w][PtrW-1] != rd_ptr_q[w][PtrW-1]) &&
                       (wr_ptr_q[w][IdxW-1:0] == rd_ptr_q[w][IdxW-1:0]);
            head[w]  = fifo_q[w][rd_ptr_q[w][IdxW-1:0]];
            // Ready comes from registered occupancy only; a full FIFO never accepts,
            // even when its head leaves this cycle.
            enq[w]   = bus.req_valid[w] && !full[w];
        end
    end

    assign bus.req_ready = ~full;

    // Each head targets exactly one bank, so a writer competes in one arbiter per cycle.
    always_comb begin
        for (int unsigned b = 0; b < BankCount; b++) begin
            for (int unsigned w = 0; w < WrCount; w++) begin
                elig[b][w] = !empty[w] && (PR_bank_bits(head[w].pr) == bank_t'(b));
            end
        end
    end

    for (genvar b = 0; b < BankCount; b++) begin : g_bank_arb
        prf_wr_rr_arbiter #(
            .N    (WrCount),
            .IdxW ($bits(prf_wr_src_t))
        ) u_arb (
            .req_i   (elig[b]),
            .ptr_i   (rr_ptr_q[b]),
            .gnt_o   (gnt[b]),
            .idx_o   (win_idx[b]),
            .valid_o (win_vld[b])
        );
    end

    always_comb begin
        deq = '0;
        for (int unsigned b = 0; b < BankCount; b++) begin
            deq = deq | gnt[b];
        end
    end

    always_comb begin
        for (int unsigned w = 0; w < WrCount; w++) begin
            wr_ptr_d[w] = wr_ptr_q[w] + PtrW'(enq[w]);
            rd_ptr_d[w] = rd_ptr_q[w] + PtrW'(deq[w]);
        end
        bank_valid_d = win_vld;
        bank_upper_d = bank_upper_q;
        bank_data_d  = bank_data_q;
        bank_src_d   = bank_src_q;
        for (int unsigned b = 0; b < BankCount; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            // Idle banks keep their last row/data/src; only valid drops.
            if (win_vld[b]) begin
                rr_ptr_d[b]     = win_idx[b];
                bank_upper_d[b] = upper_PR_bits(head[win_idx[b]].pr);
                bank_data_d[b]  = head[win_idx[b]].data;
                bank_src_d[b]   = win_idx[b];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned w = 0; w < WrCount; w++) begin
                wr_ptr_q[w] <= '0;
                rd_ptr_q[w] <= '0;
            end
            for (int unsigned b = 0; b < BankCount; b++) begin
                rr_ptr_q[b] <= prf_wr_src_t'(WrCount - 1);
            end
            bank_valid_q <= '0;
            bank_upper_q <= '0;
            bank_data_q  <= '0;
            bank_src_q   <= '0;
        end else begin
            for (int unsigned w = 0; w < WrCount; w++) begin
                wr_ptr_q[w] <= wr_ptr_d[w];
                rd_ptr_q[w] <= rd_ptr_d[w];
            end
            for (int unsigned b = 0; b < BankCount; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
            bank_valid_q <= bank_valid_d;
            bank_upper_q <= bank_upper_d;
            bank_data_q  <= bank_data_d;
            bank_src_q   <= bank_src_d;
        end
    end

    // Entry storage needs no reset: emptiness is tracked by the pointers.
    always_ff @(posedge CLK) begin
        for (int unsigned w = 0; w < WrCount; w++) begin
            if (enq[w]) begin
                fifo_q[w][wr_ptr_q[w][IdxW-1:0]] <= '{pr: bus.req_PR[w], data: bus.req_data[w]};
            end
        end
    end

    assign bus.bank_wr_valid    = bank_valid_q;
    assign bus.bank_wr_upper_PR = bank_upper_q;
    assign bus.bank_wr_data     = bank_data_q;
    assign bus.bank_wr_src      = bank_src_q;

`ifndef SYNTHESIS
    // A write offered to a full FIFO is dropped; writers must honour ready.
    enq_when_full_a: assert property (@(posedge CLK) disable iff (!nRST)
        (bus.req_valid & ~bus.req_ready) == '0)
        else $error("prf_wr_bank_arbiter: write offered while not ready");
`endif

endmodule

// File: tb/tb_prf_wr_bank_arbiter.sv
module tb_prf_wr_bank_arbiter;
    import prf_wr_bank_arbiter_pkg::*;

    typedef struct {
        int    cyc;
        int    src;
        int    upper;
        data_t data;
    } log_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    prf_wr_bank_arbiter_if bus ();

    prf_wr_bank_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Stimulus drive registers
    logic  [7:0] drv_valid = '0;
    PR_t   [7:0] drv_pr    = '0;
    data_t [7:0] drv_data  = '0;
    bit          force_all = 1'b1;
    assign bus.req_valid = drv_valid;
    assign bus.req_PR    = drv_pr;
    assign bus.req_data  = drv_data;

    wr_entry_t pend [8][$];   // writes each writer still wants to issue
    wr_entry_t mq   [8][$];   // model FIFO contents
    int        mptr [4];
    logic        m_valid [4];
    upper_PR_t   m_upper [4];
    data_t       m_data  [4];
    prf_wr_src_t m_src   [4];
    log_t        wlog [4][$];
    int          cyc = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 8; w++) mq[w].delete();
        for (int b = 0; b < 4; b++) begin
            mptr[b] = 7;
            m_valid[b] = 1'b0;
            m_upper[b] = '0;
            m_data[b] = '0;
            m_src[b] = '0;
        end
    endtask

    // One clock of the arbiter's rules: each bank picks the first eligible head after its last
    // winner; winners leave their queue; accepted requests are appended.
    task automatic model_step();
        bit rdy [8];
        bit dq  [8];
        int win;
        int w;
        for (int i = 0; i < 8; i++) begin
            rdy[i] = mq[i].size() < 2;
            dq[i]  = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            win = -1;
            for (int i = 1; i <= 8; i++) begin
                w = (mptr[b] + i) % 8;
                if (win < 0 && mq[w].size() > 0 && mq[w][0].pr[1:0] == 2'(b)) win = w;
            end
            if (win >= 0) begin
                m_valid[b] = 1'b1;
                m_upper[b] = mq[win][0].pr[6:2];
                m_data[b]  = mq[win][0].data;
                m_src[b]   = 3'(win);
                mptr[b]    = win;
                dq[win]    = 1'b1;
            end else begin
                m_valid[b] = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) if (dq[i]) void'(mq[i].pop_front());
        for (int i = 0; i < 8; i++) begin
            if (bus.req_valid[i] && rdy[i]) begin
                mq[i].push_back('{pr: bus.req_PR[i], data: bus.req_data[i]});
                if (pend[i].size() > 0) void'(pend[i].pop_front());
            end
        end
    endtask

    always @(posedge CLK) if (nRST) model_step();
    always @(negedge nRST) model_reset();

    // Compare every cycle, then log observed bank writes for the directed checks.
    always @(negedge CLK) begin
        cyc++;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("bank%0d_valid", b), 64'(bus.bank_wr_valid[b]), 64'(m_valid[b]));
            check($sformatf("bank%0d_upper", b), 64'(bus.bank_wr_upper_PR[b]), 64'(m_upper[b]));
            check($sformatf("bank%0d_data", b), 64'(bus.bank_wr_data[b]), 64'(m_data[b]));
            check($sformatf("bank%0d_src", b), 64'(bus.bank_wr_src[b]), 64'(m_src[b]));
            if (bus.bank_wr_valid[b])
                wlog[b].push_back('{cyc: cyc, src: int'(bus.bank_wr_src[b]),
                                    upper: int'(bus.bank_wr_upper_PR[b]),
                                    data: bus.bank_wr_data[b]});
        end
        for (int w = 0; w < 8; w++)
            check($sformatf("ready%0d", w), 64'(bus.req_ready[w]), 64'(mq[w].size() < 2));
    end

    // Driver: offer the next pending write only when the writer's FIFO is ready.
    always @(negedge CLK) begin
        for (int w = 0; w < 8; w++) begin
            if (force_all) begin
                drv_valid[w] = 1'b1;
                drv_pr[w]    = '0;
                drv_data[w]  = '0;
            end else if (pend[w].size() > 0 && bus.req_ready[w]) begin
                drv_valid[w] = 1'b1;
                drv_pr[w]    = pend[w][0].pr;
                drv_data[w]  = pend[w][0].data;
            end else begin
                drv_valid[w] = 1'b0;
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        for (int b = 0; b < 4; b++) wlog[b].delete();
    endtask

    function automatic int log_total();
        return wlog[0].size() + wlog[1].size() + wlog[2].size() + wlog[3].size();
    endfunction

    task automatic add(input int w, input PR_t pr, input data_t d);
        pend[w].push_back('{pr: pr, data: d});
    endtask

    initial begin
        int p;
        int cnt [8];
        int last [8];
        int max_gap;
        int k;
        model_reset();

        // Reset held with every writer requesting
        repeat (3) @(negedge CLK);
        #1;
        check("rst_bank_valid", 64'(bus.bank_wr_valid), 64'h0);
        check("rst_ready", 64'(bus.req_ready), 64'hFF);
        sync();
        force_all = 1'b0;
        nRST      = 1'b1;
        repeat (4) @(negedge CLK);
        check("rst_no_writes", 64'(log_total()), 64'd0);

        // Conflict on bank 0: order 0,3,5 starting from reset pointer
        sync();
        clear_log();
        p = cyc;
        add(0, 7'h04, 32'hA000_0000);
        add(3, 7'h08, 32'hA000_0003);
        add(5, 7'h0C, 32'hA000_0005);
        repeat (8) @(negedge CLK);
        check("cf_cnt", 64'(wlog[0].size()), 64'd3);
        check("cf_others", 64'(log_total()), 64'd3);
        if (wlog[0].size() == 3) begin
            check("cf_src0", 64'(wlog[0][0].src), 64'd0);
            check("cf_src1", 64'(wlog[0][1].src), 64'd3);
            check("cf_src2", 64'(wlog[0][2].src), 64'd5);
            check("cf_up0", 64'(wlog[0][0].upper), 64'd1);
            check("cf_up2", 64'(wlog[0][2].upper), 64'd3);
            check("cf_lat", 64'(wlog[0][0].cyc - p), 64'd3);
            check("cf_back2back", 64'(wlog[0][2].cyc - wlog[0][0].cyc), 64'd2);
            check("cf_data1", 64'(wlog[0][1].data), 64'hA000_0003);
        end

        // Parallel: four writers, four banks, same cycle
        sync();
        clear_log();
        p = cyc;
        add(1, 7'h11, 32'hB000_0001);
        add(2, 7'h12, 32'hB000_0002);
        add(3, 7'h13, 32'hB000_0003);
        add(4, 7'h10, 32'hB000_0004);
        repeat (6) @(negedge CLK);
        check("par_total", 64'(log_total()), 64'd4);
        for (int b = 0; b < 4; b++) begin
            if (wlog[b].size() == 1) begin
                check($sformatf("par_cyc%0d", b), 64'(wlog[b][0].cyc - p), 64'd3);
                check($sformatf("par_up%0d", b), 64'(wlog[b][0].upper), 64'd4);
                check($sformatf("par_src%0d", b), 64'(wlog[b][0].src), (b == 0) ? 64'd4 : 64'(b));
            end
        end

        // Backpressure on bank 1: steer bank-1 pointer to 5 so writer 6 is favoured
        sync();
        add(5, 7'h05, 32'hC000_0005);
        repeat (5) @(negedge CLK);
        sync();
        clear_log();
        for (int i = 0; i < 5; i++) add(6, PR_t'(7'h21 + 4 * i), 32'h6000_0000 + i);
        add(2, 7'h01, 32'hD000_0000);
        add(2, 7'h09, 32'hD000_0001);
        add(2, 7'h0D, 32'hD000_0002);
        repeat (3) @(negedge CLK);
        #1;
        check("bp_ready2_low", 64'(bus.req_ready[2]), 64'd0);
        check("bp_first_grant", (wlog[1].size() == 1) ? 64'(wlog[1][0].src) : 64'hFF, 64'd6);
        repeat (20) @(negedge CLK);
        check("bp_total", 64'(wlog[1].size()), 64'd8);
        if (wlog[1].size() >= 2) check("bp_second_grant", 64'(wlog[1][1].src), 64'd2);
        k = 0;
        for (int i = 0; i < wlog[1].size(); i++) begin
            if (wlog[1][i].src == 2) begin
                check($sformatf("bp_order%0d", k), 64'(wlog[1][i].data), 64'hD000_0000 + k);
                k++;
            end
        end
        check("bp_w2_count", 64'(k), 64'd3);

        // Fairness: all writers hammer bank 2
        sync();
        clear_log();
        for (int w = 0; w < 8; w++)
            for (int i = 0; i < 12; i++)
                add(w, PR_t'({5'((w * 4 + i) % 32), 2'b10}), 32'hF000_0000 + 32'(w * 256 + i));
        repeat (110) @(negedge CLK);
        check("fair_total", 64'(wlog[2].size()), 64'd96);
        for (int w = 0; w < 8; w++) begin
            cnt[w]  = 0;
            last[w] = -1;
        end
        max_gap = 0;
        for (int i = 0; i < wlog[2].size(); i++) begin
            if (i >= 8 && i < 72) cnt[wlog[2][i].src]++;
            if (last[wlog[2][i].src] >= 0 && wlog[2][i].cyc - last[wlog[2][i].src] > max_gap)
                max_gap = wlog[2][i].cyc - last[wlog[2][i].src];
            last[wlog[2][i].src] = wlog[2][i].cyc;
        end
        for (int w = 0; w < 8; w++) check($sformatf("fair_cnt%0d", w), 64'(cnt[w]), 64'd8);
        check("fair_gap_le8", 64'(max_gap <= 8), 64'd1);

        // Asynchronous reset mid-stream with FIFOs full
        sync();
        for (int w = 0; w < 8; w++)
            for (int i = 0; i < 3; i++) add(w, PR_t'({5'(i + 1), 2'(w)}), 32'hE000_0000 + 32'(w));
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("ar_valid", 64'(bus.bank_wr_valid), 64'h0);
        check("ar_upper", 64'(bus.bank_wr_upper_PR), 64'h0);
        check("ar_data", 64'(bus.bank_wr_data[0] | bus.bank_wr_data[1] |
                             bus.bank_wr_data[2] | bus.bank_wr_data[3]), 64'h0);
        check("ar_src", 64'(bus.bank_wr_src), 64'h0);
        check("ar_ready", 64'(bus.req_ready), 64'hFF);
        for (int w = 0; w < 8; w++) pend[w].delete();
        clear_log();
        #1;
        nRST = 1'b1;
        // Pointer must be back at 7: writer 0 beats writer 7 on bank 0
        sync();
        add(0, 7'h44, 32'h1234_0000);
        add(7, 7'h48, 32'h1234_0007);
        repeat (8) @(negedge CLK);
        check("ar_total", 64'(log_total()), 64'd2);
        if (wlog[0].size() == 2) begin
            check("ar_rr_first", 64'(wlog[0][0].src), 64'd0);
            check("ar_rr_second", 64'(wlog[0][1].data), 64'h1234_0007);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
